// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// pc_fetch_unit : PC register + one-outstanding-request instruction fetch FSM
// Optional: define FETCH_PERF_CNT_EN for fetch/redirect perf counters. Rev 1.0
// ============================================================================
module pc_fetch_unit #(
  parameter int                  WordSize    = 32,
  parameter logic [WordSize-1:0] ResetVector = 32'h0000_0000,
  parameter logic [WordSize-1:0] NopInstr    = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                redirect,
  input  logic [WordSize-1:0] redirect_addr,
  output logic                imem_req,
  output logic [WordSize-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [WordSize-1:0] imem_rdata,
  output logic                if_valid,
  input  logic                id_ready,
  output logic [WordSize-1:0] if_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_redirect_cnt,
`endif
  output logic [WordSize-1:0] if_instr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_KILL  = 2'd3
  } state_t;

  state_t              state;
  logic [WordSize-1:0] pc;
  logic [WordSize-1:0] req_addr;
  logic [WordSize-1:0] redir_pc;
  logic                unused_redirect_low;

  assign redir_pc            = {redirect_addr[WordSize-1:2], 2'b00};
  assign unused_redirect_low = ^redirect_addr[1:0];

  assign imem_req  = (state == ST_FETCH) || (state == ST_KILL);
  assign imem_addr = req_addr;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      pc       <= ResetVector;
      req_addr <= ResetVector;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= NopInstr;
    end else begin
      if (redirect) begin
        pc <= redir_pc;
      end
      case (state)
        ST_IDLE: begin
          req_addr <= redirect ? redir_pc : pc;
          state    <= ST_FETCH;
        end
        ST_FETCH: begin
          // A redirect never moves an outstanding address; it waits it out in KILL.
          if (redirect) begin
            if (imem_ack) begin
              req_addr <= redir_pc;
            end else begin
              state <= ST_KILL;
            end
          end else if (imem_ack) begin
            if_instr <= imem_rdata;
            if_pc    <= req_addr;
            if_valid <= 1'b1;
            pc       <= req_addr + WordSize'(4);
            state    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            if_valid <= 1'b0;
            if_instr <= NopInstr;
            req_addr <= redir_pc;
            state    <= ST_FETCH;
          end else if (id_ready) begin
            if_valid <= 1'b0;
            req_addr <= pc;
            state    <= ST_FETCH;
          end
        end
        ST_KILL: begin
          if (imem_ack) begin
            req_addr <= redirect ? redir_pc : pc;
            state    <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_fetch_cnt    <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (if_valid && id_ready && (perf_fetch_cnt != 32'hFFFF_FFFF)) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (redirect && (perf_redirect_cnt != 32'hFFFF_FFFF)) begin
        perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_pc_fetch_unit : random + directed bench with a PC-stream reference model
// Rev 1.0
// ============================================================================
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam int          STALL_MAX = 100;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_ready = 1'b0;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_instr;

  // Second instance: reset vector at the top of the address space, always-ack memory.
  logic        redirect2 = 1'b0;
  logic [31:0] redirect_addr2 = '0;
  logic        ack2 = 1'b1;
  logic [31:0] rdata2 = 32'hCAFE_0001;
  logic        ready2 = 1'b1;
  logic        req2, valid2;
  logic [31:0] addr2, pc2, instr2;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_redirect_cnt, perf_fetch_cnt2, perf_redirect_cnt2;
`endif

  pc_fetch_unit dut (
    .clk(clk), .rstn(rstn), .redirect(redirect), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .id_ready(id_ready),
    .if_pc(if_pc),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt(perf_fetch_cnt), .perf_redirect_cnt(perf_redirect_cnt),
`endif
    .if_instr(if_instr)
  );

  pc_fetch_unit #(.ResetVector(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rstn(rstn), .redirect(redirect2), .redirect_addr(redirect_addr2),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2),
    .imem_rdata(rdata2), .if_valid(valid2), .id_ready(ready2),
    .if_pc(pc2),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_cnt(perf_fetch_cnt2), .perf_redirect_cnt(perf_redirect_cnt2),
`endif
    .if_instr(instr2)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          lat_cfg = 0;
  int          wait_cnt = 0;
  bit          junk_ack = 1'b0;
  logic [31:0] exp_pc = '0;
  int          n_hs = 0;
  int          n_rd = 0;
  int          stall = 0;
  logic [31:0] q2[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic int next_lat();
    return (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory model: ack after wait_cnt extra cycles, data is a hash of the address.
  task automatic respond();
    if (imem_req === 1'b1) begin
      if (wait_cnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wait_cnt   = next_lat();
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        wait_cnt--;
      end
    end else begin
      wait_cnt   = next_lat();
      imem_ack   = junk_ack && ($urandom_range(0, 3) == 0);
      imem_rdata = $urandom;
    end
  endtask

  // One clock: snapshot this cycle, cross the edge, update the model, respond.
  task automatic tick();
    logic        s_rst, s_req, s_ack, s_val, s_rdy, s_red;
    logic [31:0] s_addr, s_pc, s_instr, s_raddr;
    s_rst = rstn; s_req = imem_req; s_ack = imem_ack; s_val = if_valid;
    s_rdy = id_ready; s_red = redirect; s_addr = imem_addr; s_pc = if_pc;
    s_instr = if_instr; s_raddr = redirect_addr;
    @(posedge clk);
    #1;
    if (s_rst) begin
      if (s_val && s_rdy) begin
        check_eq("hs_pc", s_pc, exp_pc);
        check_eq("hs_instr", s_instr, mem_word(exp_pc));
        exp_pc += 32'd4;
        n_hs++;
        stall = 0;
      end else begin
        stall++;
      end
      if (s_red) begin
        exp_pc = {s_raddr[31:2], 2'b00};
        n_rd++;
      end
      if (rstn && s_req && !s_ack) begin
        check_eq("req_held", imem_req, 1);
        check_eq("addr_held", imem_addr, s_addr);
      end
      if (stall == STALL_MAX) begin
        check_eq("progress_timeout", 32'(stall), 0);
        stall = 0;
      end
    end
    if (imem_req === 1'b1) check_eq("addr_align", {30'd0, imem_addr[1:0]}, 0);
    if (rstn && req2 && q2.size() < 2) q2.push_back(addr2);
    respond();
  endtask

  task automatic do_reset();
    rstn = 1'b0; redirect = 1'b0; id_ready = 1'b0;
    repeat (3) tick();
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_valid", if_valid, 0);
    check_eq("rst_pc", if_pc, 32'h0);
    check_eq("rst_instr", if_instr, NOP);
    check_eq("rst_addr_wrap", addr2, 32'hFFFF_FFFC);
`ifdef FETCH_PERF_CNT_EN
    check_eq("rst_perf_fetch", perf_fetch_cnt, 0);
    check_eq("rst_perf_redir", perf_redirect_cnt, 0);
`endif
    exp_pc = 32'h0; n_hs = 0; n_rd = 0; stall = 0;
    q2.delete();
    rstn = 1'b1;
  endtask

  initial begin
    logic [31:0] acc[$];
    logic [31:0] hold_pc, hold_instr;

    // Back-to-back fetches with single-cycle ack.
    lat_cfg = 0; junk_ack = 1'b0;
    do_reset();
    id_ready = 1'b1;
    for (int i = 0; i < 30 && acc.size() < 3; i++) begin
      if (imem_req && imem_ack) acc.push_back(imem_addr);
      tick();
    end
    check_eq("seq_count", acc.size(), 3);
    if (acc.size() == 3) begin
      check_eq("seq_addr0", acc[0], 32'h0);
      check_eq("seq_addr1", acc[1], 32'h4);
      check_eq("seq_addr2", acc[2], 32'h8);
    end
    check_eq("wrap_count", q2.size(), 2);
    if (q2.size() == 2) begin
      check_eq("wrap_req0", q2[0], 32'hFFFF_FFFC);
      check_eq("wrap_req1", q2[1], 32'h0);
    end

    // Decode back-pressure holds the output register.
    id_ready = 1'b0;
    for (int i = 0; i < 20 && !if_valid; i++) tick();
    check_eq("stall_valid0", if_valid, 1);
    hold_pc = if_pc; hold_instr = if_instr;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_valid", if_valid, 1);
      check_eq("stall_pc", if_pc, hold_pc);
      check_eq("stall_instr", if_instr, hold_instr);
      check_eq("stall_req", imem_req, 0);
    end
    id_ready = 1'b1;

    // Redirect during an outstanding request.
    lat_cfg = 3;
    do_reset();
    id_ready = 1'b1;
    for (int i = 0; i < 80 && !(imem_req && imem_addr == 32'h8 && !imem_ack && wait_cnt == 2); i++)
      tick();
    check_eq("kill_reach", imem_addr, 32'h8);
    redirect = 1'b1; redirect_addr = 32'h100;
    tick();
    redirect = 1'b0;
    check_eq("kill_req", imem_req, 1);
    check_eq("kill_addr", imem_addr, 32'h8);
    for (int i = 0; i < 20 && !(imem_req && imem_addr != 32'h8); i++) tick();
    check_eq("kill_next_addr", imem_addr, 32'h100);
    for (int i = 0; i < 20 && !if_valid; i++) tick();
    check_eq("kill_first_pc", if_pc, 32'h100);
    check_eq("kill_first_instr", if_instr, mem_word(32'h100));

    // Redirect while holding with decode ready.
    lat_cfg = 1;
    id_ready = 1'b0;
    for (int i = 0; i < 20 && !if_valid; i++) tick();
    check_eq("hold_valid", if_valid, 1);
    id_ready = 1'b1; redirect = 1'b1; redirect_addr = 32'h203;
    tick();
    redirect = 1'b0;
    check_eq("flush_valid", if_valid, 0);
    check_eq("flush_instr", if_instr, NOP);
    check_eq("flush_req", imem_req, 1);
    check_eq("flush_addr", imem_addr, 32'h200);

    // Randomized traffic against the PC-stream model.
    do_reset();
    lat_cfg = -1; junk_ack = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      id_ready = ($urandom_range(0, 9) < 7);
      redirect = ($urandom_range(0, 24) == 0);
      redirect_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
      tick();
    end
    redirect = 1'b0; id_ready = 1'b0;
    check_eq("rand_progress", (n_hs > 100) ? 32'd1 : 32'd0, 1);
`ifdef FETCH_PERF_CNT_EN
    check_eq("perf_fetch", perf_fetch_cnt, n_hs);
    check_eq("perf_redirect", perf_redirect_cnt, n_rd);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
